// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO and serialises each one onto
// uart_txd as start + 8 data bits (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx_engine #(
    parameter int unsigned MIN_DIV   = 4,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 uart_txd,
    output logic                 busy,
    output logic                 byte_done
);

    localparam int unsigned BIT_W = 3;
    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE_W     = DIV_WIDTH'(1);
    localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q;
    logic [7:0]           shift_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 two_stop_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 done_q;

    logic [DIV_WIDTH-1:0] div_d;
    logic                 par_d;
    logic                 bit_end_c;

    // Frame configuration captured in LOAD; divisor clamped so a bit is never shorter than MIN_DIV.
    assign div_d     = (baud_div < MIN_DIV_W) ? MIN_DIV_W : baud_div;
    assign par_d     = (^tx_data) ^ parity_odd;
    assign bit_end_c = (cnt_q == '0);

    // Pop strobe leaves IDLE on the same edge, so it is high for one cycle per frame.
    assign tx_ready  = (state_q == S_IDLE) && enable && tx_valid && !rst;

    assign uart_txd  = txd_q;
    assign busy      = busy_q;
    assign byte_done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_ready) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    shift_q    <= tx_data;
                    div_q      <= div_d;
                    par_en_q   <= parity_en;
                    par_bit_q  <= par_d;
                    two_stop_q <= two_stop;
                    cnt_q      <= div_d - ONE_W;
                    bit_q      <= '0;
                    txd_q      <= 1'b0;
                    state_q    <= S_START;
                end
                S_START: begin
                    if (bit_end_c) begin
                        cnt_q   <= div_q - ONE_W;
                        txd_q   <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q - ONE_W;
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        cnt_q <= div_q - ONE_W;
                        if (bit_q == LAST_BIT) begin
                            bit_q <= '0;
                            if (par_en_q) begin
                                txd_q   <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - ONE_W;
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        cnt_q   <= div_q - ONE_W;
                        bit_q   <= '0;
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - ONE_W;
                    end
                end
                S_STOP: begin
                    txd_q <= 1'b1;
                    if (bit_end_c) begin
                        // bit_q marks whether the second stop bit is already running
                        if (two_stop_q && (bit_q == '0)) begin
                            bit_q <= BIT_W'(1);
                            cnt_q <= div_q - ONE_W;
                        end else begin
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - ONE_W;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed vector table, hand-written corner sequences and
// randomized traffic, all checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid;
    logic        tx_ready;
    logic        enable;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
    logic        uart_txd;
    logic        busy;
    logic        byte_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // FIFO stand-in with one-cycle read latency
    logic [7:0] mem [256];
    logic [7:0] push_cnt = 8'd0;
    logic [7:0] pop_cnt  = 8'd0;
    logic       valid_en = 1'b0;

    assign tx_valid = valid_en && (push_cnt != pop_cnt);

    uart_tx_engine dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .enable     (enable),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tx_ready) begin
            tx_data <= mem[pop_cnt];
            pop_cnt <= pop_cnt + 8'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is a list of bits, each held for eff_div cycles.
    logic       chk_en  = 1'b0;
    logic       line_q [$];
    logic       bits_q [$];
    int         free_at = 0;
    int         done_at = -1;
    logic       load_pend = 1'b0;
    logic [7:0] m_byte  = 8'h00;
    logic [7:0] m_rd    = 8'd0;
    int         m_eff;
    logic       e_txd, e_busy, e_done, e_ready;

    always @(negedge clk) begin
        if (chk_en) begin
            e_txd   = (line_q.size() != 0) ? line_q[0] : 1'b1;
            e_busy  = (cyc < free_at);
            e_done  = (cyc == done_at);
            e_ready = (cyc >= free_at) && enable && tx_valid && !rst;
            check("cycle {txd,busy,done,ready}", 32'({uart_txd, busy, byte_done, tx_ready}),
                  32'({e_txd, e_busy, e_done, e_ready}));
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (rst) begin
                line_q.delete();
                free_at   = cyc + 1;
                done_at   = -1;
                load_pend = 1'b0;
            end else begin
                if (load_pend) begin
                    m_eff = (baud_div < 16'd4) ? 4 : int'(baud_div);
                    bits_q.delete();
                    bits_q.push_back(1'b0);
                    for (int i = 0; i < 8; i++) bits_q.push_back(m_byte[i]);
                    if (parity_en) bits_q.push_back((^m_byte) ^ parity_odd);
                    bits_q.push_back(1'b1);
                    if (two_stop) bits_q.push_back(1'b1);
                    foreach (bits_q[j]) repeat (m_eff) line_q.push_back(bits_q[j]);
                    free_at   = cyc + 1 + bits_q.size() * m_eff;
                    done_at   = free_at;
                    load_pend = 1'b0;
                end
                if (e_ready) begin
                    load_pend = 1'b1;
                    free_at   = 32'h7fff_ffff;
                    m_byte    = mem[m_rd];
                    m_rd      = m_rd + 8'd1;
                end
            end
        end
    end

    // Observation window shared by the directed tests
    logic cap_s [1024];
    int   cap_pop [$];
    int   cap_done [$];

    task automatic capture(input int n);
        cap_pop.delete();
        cap_done.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_s[k] = uart_txd;
            if (tx_ready) cap_pop.push_back(k);
            if (byte_done) cap_done.push_back(k);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[push_cnt] = d;
        push_cnt = push_cnt + 8'd1;
    endtask

    function automatic logic [7:0] decode(input int start, input int eff);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = cap_s[start + eff * (1 + b) + eff / 2];
        return r;
    endfunction

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        pe;
        logic        po;
        logic        ts;
        int          eff;
        int          len;
        logic        par;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v);
        int p;
        @(posedge clk); #1;
        baud_div = v.div; parity_en = v.pe; parity_odd = v.po; two_stop = v.ts;
        enable = 1'b1; valid_en = 1'b1;
        push(v.data);
        capture(120);
        check("vec pop count", 32'(cap_pop.size()), 32'd1);
        check("vec done count", 32'(cap_done.size()), 32'd1);
        if (cap_pop.size() == 1 && cap_done.size() == 1) begin
            p = cap_pop[0];
            check("vec done offset", 32'(cap_done[0] - p), 32'(v.len + 2));
            check("vec high before start", 32'(cap_s[p + 1]), 32'd1);
            check("vec start bit", 32'(cap_s[p + 2]), 32'd0);
            check("vec data", 32'(decode(p + 2, v.eff)), 32'(v.data));
            if (v.pe) check("vec parity bit", 32'(cap_s[p + 2 + v.eff * 9 + v.eff / 2]), 32'(v.par));
            check("vec last stop high", 32'(cap_s[cap_done[0] - 1]), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0, lows, guard;
        logic [7:0] exp_b [3];

        rst = 1'b1; enable = 1'b0; baud_div = 16'd8;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Directed frame formats, including divisor clamping
        vecs[0] = '{8'h55, 16'd8, 1'b0, 1'b0, 1'b0, 8, 80, 1'b0};
        vecs[1] = '{8'h07, 16'd8, 1'b1, 1'b0, 1'b0, 8, 88, 1'b1};
        vecs[2] = '{8'h07, 16'd8, 1'b1, 1'b1, 1'b0, 8, 88, 1'b0};
        vecs[3] = '{8'h3C, 16'd2, 1'b0, 1'b0, 1'b1, 4, 44, 1'b0};
        vecs[4] = '{8'h00, 16'd0, 1'b1, 1'b1, 1'b0, 4, 44, 1'b1};
        vecs[5] = '{8'hFF, 16'd5, 1'b1, 1'b0, 1'b1, 5, 60, 1'b0};
        vecs[6] = '{8'h81, 16'd4, 1'b0, 1'b0, 1'b0, 4, 40, 1'b0};
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Back-to-back frames from a preloaded FIFO
        @(posedge clk); #1;
        baud_div = 16'd4; parity_en = 1'b0; two_stop = 1'b0; enable = 1'b1; valid_en = 1'b1;
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
        for (int i = 0; i < 3; i++) push(exp_b[i]);
        capture(200);
        check("b2b pop count", 32'(cap_pop.size()), 32'd3);
        check("b2b done count", 32'(cap_done.size()), 32'd3);
        if (cap_pop.size() == 3) begin
            check("b2b spacing 0-1", 32'(cap_pop[1] - cap_pop[0]), 32'd42);
            check("b2b spacing 1-2", 32'(cap_pop[2] - cap_pop[1]), 32'd42);
            for (int i = 0; i < 3; i++)
                check("b2b data", 32'(decode(cap_pop[i] + 2, 4)), 32'(exp_b[i]));
        end

        // enable low holds off a pending byte; raising it pops in the same cycle
        @(posedge clk); #1;
        enable = 1'b0;
        push(8'h5A);
        capture(20);
        lows = 0;
        for (int k = 0; k < 20; k++) if (cap_s[k] == 1'b0) lows++;
        check("disabled pop count", 32'(cap_pop.size()), 32'd0);
        check("disabled line low cycles", 32'(lows), 32'd0);
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        check("enable rise pop", 32'(tx_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        push(8'h6B);
        capture(80);
        check("enable drop done count", 32'(cap_done.size()), 32'd1);
        check("enable drop pop count", 32'(cap_pop.size()), 32'd0);
        @(posedge clk); #1 enable = 1'b1;
        capture(60);
        check("re-enable pop count", 32'(cap_pop.size()), 32'd1);
        check("re-enable done count", 32'(cap_done.size()), 32'd1);

        // Reset mid-frame with another byte waiting
        @(posedge clk); #1;
        baud_div = 16'd8;
        push(8'h5A);
        push(8'h33);
        capture(20);
        check("pre-reset pop count", 32'(cap_pop.size()), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        p0 = int'(pop_cnt);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset txd", 32'(uart_txd), 32'd1);
            check("reset busy", 32'(busy), 32'd0);
            check("reset tx_ready", 32'(tx_ready), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        check("reset pop count", 32'(pop_cnt), 32'(p0));
        capture(100);
        check("post-reset pop count", 32'(cap_pop.size()), 32'd1);
        check("post-reset done count", 32'(cap_done.size()), 32'd1);

        // Randomized traffic, configuration churn and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 11) == 0 && (push_cnt - pop_cnt) < 8'd6) push(8'($urandom));
            valid_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) begin
                baud_div   = 16'($urandom_range(0, 6));
                parity_en  = 1'($urandom_range(0, 1));
                parity_odd = 1'($urandom_range(0, 1));
                two_stop   = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b1; valid_en = 1'b1;
        guard = 0;
        while ((push_cnt != pop_cnt || busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain within budget", 32'(guard < 2000), 32'd1);
        repeat (3) @(negedge clk);
        check("total pops vs model", 32'(pop_cnt), 32'(m_rd));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
